// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, per-bit edge/bit counting and
// single-cycle strobes for sampler, deserializer and checkers. Optional error
// flag outputs are enabled by defining UART_RX_ERR_FLAGS_EN.
module uart_rx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_clr,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
  output logic                      parity_error,
  output logic                      framing_error,
`endif
  output logic                      data_valid
);

  localparam int PW    = PRESCALE_WIDTH;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    edge_q, edge_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             par_en_q, par_en_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  logic             samp_q, samp_d;
  logic             clr_q, clr_d;
  logic             den_q, den_d;
  logic             strt_q, strt_d;
  logic             parc_q, parc_d;
  logic             stpc_q, stpc_d;
  logic             dv_q, dv_d;
`ifdef UART_RX_ERR_FLAGS_EN
  logic             pflag_q, pflag_d;
  logic             fflag_q, fflag_d;
`endif

  logic [PW-1:0]    last_edge;
  logic [PW-1:0]    edge_inc;
  logic [PW-1:0]    ck_nxt;
  logic             at_last;

  // Check point CK = P/2+2 is taken from the prescale that will be in force next cycle,
  // so the strobes come out registered and aligned with edge_cnt.
  assign last_edge = pre_q - PW'(1);
  assign at_last   = (edge_q == last_edge);
  assign edge_inc  = at_last ? '0 : edge_q + PW'(1);
  assign ck_nxt    = (pre_d >> 1) + PW'(2);

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    pre_d    = pre_q;
    par_en_d = par_en_q;
    bit_d    = bit_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    dv_d     = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
    pflag_d  = 1'b0;
    fflag_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!RX_IN) begin
          state_d  = S_START;
          edge_d   = PW'(1);
          pre_d    = Prescale;
          par_en_d = PAR_EN;
        end
      end
      S_START: begin
        edge_d = edge_inc;
        if (strt_q && strt_glitch) begin
          state_d = S_IDLE;
          edge_d  = '0;
`ifdef UART_RX_ERR_FLAGS_EN
          fflag_d = 1'b1;
`endif
        end else if (at_last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        edge_d = edge_inc;
        if (at_last) begin
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        edge_d = edge_inc;
        if (parc_q && par_err) perr_d = 1'b1;
        if (at_last) state_d = S_STOP;
      end
      S_STOP: begin
        edge_d = edge_inc;
        // Leave right after the stop check so a following start edge is not missed.
        if (stpc_q) begin
          state_d = S_DONE;
          edge_d  = '0;
          ferr_d  = ferr_q | stp_err;
          dv_d    = !(perr_q | ferr_q | stp_err);
`ifdef UART_RX_ERR_FLAGS_EN
          pflag_d = perr_q;
          fflag_d = ferr_q | stp_err;
`endif
        end
      end
      S_DONE: begin
        edge_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (RX_IN) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
      end
    endcase
  end

  always_comb begin
    samp_d = state_d inside {S_START, S_DATA, S_PARITY, S_STOP};
    clr_d  = (state_q == S_IDLE) && (state_d == S_START);
    strt_d = (state_d == S_START)  && (edge_d == ck_nxt);
    den_d  = (state_d == S_DATA)   && (edge_d == ck_nxt);
    parc_d = (state_d == S_PARITY) && (edge_d == ck_nxt);
    stpc_d = (state_d == S_STOP)   && (edge_d == ck_nxt);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      edge_q   <= '0;
      pre_q    <= '0;
      par_en_q <= 1'b0;
      bit_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      samp_q   <= 1'b0;
      clr_q    <= 1'b0;
      den_q    <= 1'b0;
      strt_q   <= 1'b0;
      parc_q   <= 1'b0;
      stpc_q   <= 1'b0;
      dv_q     <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
      pflag_q  <= 1'b0;
      fflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      pre_q    <= pre_d;
      par_en_q <= par_en_d;
      bit_q    <= bit_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      samp_q   <= samp_d;
      clr_q    <= clr_d;
      den_q    <= den_d;
      strt_q   <= strt_d;
      parc_q   <= parc_d;
      stpc_q   <= stpc_d;
      dv_q     <= dv_d;
`ifdef UART_RX_ERR_FLAGS_EN
      pflag_q  <= pflag_d;
      fflag_q  <= fflag_d;
`endif
    end
  end

  assign edge_cnt    = edge_q;
  assign dat_samp_en = samp_q;
  assign deser_clr   = clr_q;
  assign deser_en    = den_q;
  assign strt_chk_en = strt_q;
  assign par_chk_en  = parc_q;
  assign stp_chk_en  = stpc_q;
  assign data_valid  = dv_q;
`ifdef UART_RX_ERR_FLAGS_EN
  assign parity_error  = pflag_q;
  assign framing_error = fflag_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames, models the checkers and
// a small LSB-first deserializer, and compares strobe timing against fixed cycles.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          par_en = 1'b0;
  logic          par_force = 1'b0;
  logic          strt_glitch, par_err, stp_err;
  logic [PW-1:0] edge_cnt;
  logic          dat_samp_en, deser_clr, deser_en;
  logic          strt_chk_en, par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
  logic          parity_error, framing_error;
`endif

  always #5 clk = ~clk;

  assign strt_glitch = strt_chk_en & rx_in;
  assign stp_err     = stp_chk_en & ~rx_in;
  assign par_err     = par_chk_en & par_force;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(PW)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .Prescale(prescale), .PAR_EN(par_en),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .deser_clr(deser_clr),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
`ifdef UART_RX_ERR_FLAGS_EN
    .parity_error(parity_error), .framing_error(framing_error),
`endif
    .data_valid(data_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit         line_q[$];
  int         dv_q[$], den_q[$], clr_q[$], strt_q[$], stp_q[$], par_q[$];
  logic [7:0] pd_q[$];
  logic [7:0] shreg;
  int         samp_last, samp_win, overlap, ec_probe, probe_at;
  int         p_chg_at;
`ifdef UART_RX_ERR_FLAGS_EN
  int         pe_q[$], fe_q[$];
`endif

  task automatic add_bits(input bit v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic add_frame(input int p, input logic [7:0] d, input bit pe, input bit stop_v);
    add_bits(1'b0, p);
    for (int i = 0; i < 8; i++) add_bits(d[i], p);
    if (pe) add_bits(^d, p);
    add_bits(stop_v, p);
  endtask

  task automatic clear_rec();
    dv_q.delete(); den_q.delete(); clr_q.delete(); strt_q.delete();
    stp_q.delete(); par_q.delete(); pd_q.delete();
`ifdef UART_RX_ERR_FLAGS_EN
    pe_q.delete(); fe_q.delete();
`endif
    samp_last = -1; samp_win = 0; ec_probe = -1; probe_at = -1; p_chg_at = -1;
    shreg = '0;
  endtask

  // Cycle c: inputs applied at the negedge before rising edge c; outputs seen then
  // are the values that edge c samples.
  task automatic run(input int ncyc, input int rst_at, input int win_lo, input int win_hi);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rx_in = (c < line_q.size()) ? line_q[c] : 1'b1;
      if (rst_at >= 0 && c == rst_at + 3) rst = 1'b0;
      if (c == p_chg_at) begin
        prescale = PW'(16);
        par_en   = 1'b1;
      end
      #1;
      if (c == rst_at) begin
        chk("samp_before_rst", {31'd0, dat_samp_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("outs_in_rst", {19'd0, edge_cnt, dat_samp_en, deser_clr, deser_en,
                            strt_chk_en, par_chk_en, stp_chk_en, data_valid}, 32'd0);
      end
      if (c == probe_at) ec_probe = int'(edge_cnt);
      if (deser_clr) begin
        clr_q.push_back(c);
        shreg = '0;
      end
      if (deser_en) begin
        den_q.push_back(c);
        shreg = {rx_in, shreg[7:1]};
      end
      if (strt_chk_en) strt_q.push_back(c);
      if (stp_chk_en) stp_q.push_back(c);
      if (par_chk_en) par_q.push_back(c);
      if (data_valid) begin
        dv_q.push_back(c);
        pd_q.push_back(shreg);
      end
`ifdef UART_RX_ERR_FLAGS_EN
      if (parity_error) pe_q.push_back(c);
      if (framing_error) fe_q.push_back(c);
`endif
      if (dat_samp_en) begin
        samp_last = c;
        if (c >= win_lo && c < win_hi) samp_win++;
      end
      if ($countones({deser_clr, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}) > 1)
        overlap++;
    end
  endtask

  initial begin
    overlap = 0;
    clear_rec();
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {19'd0, edge_cnt, dat_samp_en, deser_clr, deser_en,
                       strt_chk_en, par_chk_en, stp_chk_en, data_valid}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_edge_cnt", {26'd0, edge_cnt}, 32'd0);

    // P=8, no parity, 0xA5; Prescale/PAR_EN changed mid-frame must be ignored
    prescale = PW'(8); par_en = 1'b0;
    line_q.delete(); add_frame(8, 8'hA5, 1'b0, 1'b1);
    clear_rec(); probe_at = 13; p_chg_at = 20;
    run(100, -1, 0, 0);
    chk("t1_dv_cnt", dv_q.size(), 1);
    chk("t1_dv_cyc", (dv_q.size() > 0) ? dv_q[0] : -1, 79);
    chk("t1_pdata", (pd_q.size() > 0) ? pd_q[0] : 8'h00, 8'hA5);
    chk("t1_den_cnt", den_q.size(), 8);
    chk("t1_den_first", (den_q.size() > 0) ? den_q[0] : -1, 14);
    chk("t1_den_last", (den_q.size() == 8) ? den_q[7] : -1, 70);
    chk("t1_clr_cyc", (clr_q.size() > 0) ? clr_q[0] : -1, 1);
    chk("t1_strt_cyc", (strt_q.size() > 0) ? strt_q[0] : -1, 6);
    chk("t1_stp_cyc", (stp_q.size() > 0) ? stp_q[0] : -1, 78);
    chk("t1_par_cnt", par_q.size(), 0);
    chk("t1_edge_probe", ec_probe, 5);

    // Start glitch at P=16: line low 3 cycles only
    prescale = PW'(16); par_en = 1'b0;
    line_q.delete(); add_bits(1'b0, 3);
    clear_rec();
    run(40, -1, 0, 0);
    chk("gl_strt_cyc", (strt_q.size() > 0) ? strt_q[0] : -1, 10);
    chk("gl_samp_last", samp_last, 10);
    chk("gl_den_cnt", den_q.size(), 0);
    chk("gl_dv_cnt", dv_q.size(), 0);
`ifdef UART_RX_ERR_FLAGS_EN
    chk("gl_ferr_cyc", (fe_q.size() > 0) ? fe_q[0] : -1, 11);
`endif

    // P=8, parity on, clean
    prescale = PW'(8); par_en = 1'b1;
    line_q.delete(); add_frame(8, 8'h5A, 1'b1, 1'b1);
    clear_rec();
    run(110, -1, 0, 0);
    chk("pg_dv_cyc", (dv_q.size() > 0) ? dv_q[0] : -1, 87);
    chk("pg_pdata", (pd_q.size() > 0) ? pd_q[0] : 8'h00, 8'h5A);
    chk("pg_par_cyc", (par_q.size() > 0) ? par_q[0] : -1, 78);

    // P=16, parity on, parity error forced
    prescale = PW'(16); par_en = 1'b1; par_force = 1'b1;
    line_q.delete(); add_frame(16, 8'h33, 1'b1, 1'b1);
    clear_rec();
    run(200, -1, 0, 0);
    par_force = 1'b0;
    chk("pb_dv_cnt", dv_q.size(), 0);
    chk("pb_par_cyc", (par_q.size() > 0) ? par_q[0] : -1, 154);
`ifdef UART_RX_ERR_FLAGS_EN
    chk("pb_perr_cyc", (pe_q.size() > 0) ? pe_q[0] : -1, 171);
    chk("pb_ferr_cnt", fe_q.size(), 0);
`endif

    // Stop bit low, line stuck low 40 more cycles, then a normal frame at 125
    prescale = PW'(8); par_en = 1'b0;
    line_q.delete();
    add_frame(8, 8'hC5, 1'b0, 1'b0);
    add_bits(1'b0, 40);
    add_bits(1'b1, 5);
    add_frame(8, 8'h96, 1'b0, 1'b1);
    clear_rec();
    run(230, -1, 79, 126);
    chk("st_dv_cnt", dv_q.size(), 1);
    chk("st_dv_cyc", (dv_q.size() > 0) ? dv_q[0] : -1, 204);
    chk("st_pdata", (pd_q.size() > 0) ? pd_q[0] : 8'h00, 8'h96);
    chk("st_samp_hold", samp_win, 0);
`ifdef UART_RX_ERR_FLAGS_EN
    chk("st_ferr_cyc", (fe_q.size() > 0) ? fe_q[0] : -1, 79);
`endif

    // Back-to-back 0x3C, 0xC3 at P=8
    line_q.delete();
    add_frame(8, 8'h3C, 1'b0, 1'b1);
    add_frame(8, 8'hC3, 1'b0, 1'b1);
    clear_rec();
    run(170, -1, 0, 0);
    chk("bb_dv_cnt", dv_q.size(), 2);
    chk("bb_dv0_cyc", (dv_q.size() > 0) ? dv_q[0] : -1, 79);
    chk("bb_dv_gap", (dv_q.size() == 2) ? dv_q[1] - dv_q[0] : -1, 80);
    chk("bb_pdata0", (pd_q.size() > 0) ? pd_q[0] : 8'h00, 8'h3C);
    chk("bb_pdata1", (pd_q.size() == 2) ? pd_q[1] : 8'h00, 8'hC3);
    chk("bb_clr_cnt", clr_q.size(), 2);
    chk("bb_clr1_cyc", (clr_q.size() == 2) ? clr_q[1] : -1, 81);

    // Reset at cycle 40 mid-DATA, then a fresh P=16 frame
    line_q.delete(); add_frame(8, 8'hFF, 1'b0, 1'b1);
    while (line_q.size() > 40) void'(line_q.pop_back());
    clear_rec();
    run(70, 40, 0, 0);
    chk("rs_dv_cnt", dv_q.size(), 0);
    prescale = PW'(16); par_en = 1'b0;
    line_q.delete(); add_frame(16, 8'h5A, 1'b0, 1'b1);
    clear_rec();
    run(170, -1, 0, 0);
    chk("rs_dv_cyc", (dv_q.size() > 0) ? dv_q[0] : -1, 155);
    chk("rs_pdata", (pd_q.size() > 0) ? pd_q[0] : 8'h00, 8'h5A);

    chk("no_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
